// File: rtl/button_event.sv
// Button gesture classifier: turns a debounced level into short/double/long press
// events, with auto-repeat while a long press is held. Port "repeat" is a reserved word, so it is named repeat_pulse.
module button_event #(
  parameter int unsigned LONG_TICKS   = 10_000_000,
  parameter int unsigned DOUBLE_TICKS = 3_000_000,
  parameter int unsigned REPEAT_TICKS = 2_000_000,
  parameter int unsigned CNT_LEN      = 24
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_level,
  output logic short_press,
  output logic double_click,
  output logic long_press,
  output logic repeat_pulse,
  output logic held
);

  // state          | meaning
  // IDLE           | button released, no gesture in progress
  // PRESSED        | first press, timing toward long press
  // WAIT_SECOND    | released after first press, waiting for a second press
  // SECOND_PRESSED | second press of a double click in progress
  // LONG_HELD      | long press reached, repeating while held
  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    PRESSED        = 3'd1,
    WAIT_SECOND    = 3'd2,
    SECOND_PRESSED = 3'd3,
    LONG_HELD      = 3'd4
  } state_t;

  localparam logic [CNT_LEN-1:0] LONG_TC   = CNT_LEN'(LONG_TICKS - 1);
  localparam logic [CNT_LEN-1:0] DOUBLE_TC = CNT_LEN'(DOUBLE_TICKS - 1);
  localparam logic [CNT_LEN-1:0] REPEAT_TC = CNT_LEN'(REPEAT_TICKS - 1);

  state_t             state, state_nxt;
  logic [CNT_LEN-1:0] cnt, cnt_nxt;
  logic               cnt_restart;
  logic               short_nxt, double_nxt, long_nxt, repeat_nxt;

  always_comb begin
    state_nxt   = state;
    cnt_restart = 1'b0;
    short_nxt   = 1'b0;
    double_nxt  = 1'b0;
    long_nxt    = 1'b0;
    repeat_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (btn_level) state_nxt = PRESSED;
      end
      PRESSED: begin
        if (!btn_level) begin
          state_nxt = WAIT_SECOND;
        end else if (cnt == LONG_TC) begin
          state_nxt = LONG_HELD;
          long_nxt  = 1'b1;
        end
      end
      WAIT_SECOND: begin
        if (btn_level) begin
          state_nxt = SECOND_PRESSED;
        end else if (cnt == DOUBLE_TC) begin
          state_nxt = IDLE;
          short_nxt = 1'b1;
        end
      end
      SECOND_PRESSED: begin
        if (!btn_level) begin
          state_nxt  = IDLE;
          double_nxt = 1'b1;
        end else if (cnt == LONG_TC) begin
          state_nxt = LONG_HELD;
          long_nxt  = 1'b1;
        end
      end
      LONG_HELD: begin
        if (!btn_level) begin
          state_nxt = IDLE;
        end else if (cnt == REPEAT_TC) begin
          repeat_nxt  = 1'b1;
          cnt_restart = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counter restarts on any state change, saturates instead of wrapping.
  always_comb begin
    if ((state_nxt != state) || cnt_restart) begin
      cnt_nxt = '0;
    end else if (cnt != {CNT_LEN{1'b1}}) begin
      cnt_nxt = cnt + 1'b1;
    end else begin
      cnt_nxt = cnt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      short_press  <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
      repeat_pulse <= 1'b0;
      held         <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      short_press  <= short_nxt;
      double_click <= double_nxt;
      long_press   <= long_nxt;
      repeat_pulse <= repeat_nxt;
      held         <= (state_nxt == LONG_HELD);
    end
  end

endmodule

// File: tb/tb_button_event.sv
// Directed bench for button_event with small tick values; every edge's outputs
// are compared against hand-derived expectations packed as {short,double,long,repeat,held}.
module tb_button_event;

  logic clk = 1'b0;
  logic reset;
  logic btn_level;
  logic short_press, double_click, long_press, repeat_pulse, held;

  int total = 0;
  int bad   = 0;

  button_event #(
    .LONG_TICKS(8),
    .DOUBLE_TICKS(4),
    .REPEAT_TICKS(3),
    .CNT_LEN(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_level(btn_level),
    .short_press(short_press),
    .double_click(double_click),
    .long_press(long_press),
    .repeat_pulse(repeat_pulse),
    .held(held)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] outs();
    return {short_press, double_click, long_press, repeat_pulse, held};
  endfunction

  task automatic test_reset();
    logic [4:0] got, exp;
    reset = 1'b1;
    btn_level = 1'b1;
    #3;
    total++;
    got = outs();
    if (got !== 5'b0) begin
      bad++;
      $display("FAIL reset_async got=%b exp=%b", got, 5'b0);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      got = outs();
      if (got !== 5'b0) begin
        bad++;
        $display("FAIL reset_hold edge=%0d got=%b exp=%b", i, got, 5'b0);
      end
    end
    reset = 1'b0;
    // btn already high at release: E0 is a fresh press, long press after E8
    for (int i = 0; i < 13; i++) begin
      btn_level = (i < 10);
      @(posedge clk); #1;
      exp = '0;
      if (i == 8) exp[2] = 1'b1;
      if (i >= 8 && i <= 9) exp[0] = 1'b1;
      got = outs();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL reset_fresh_press edge=%0d got=%b exp=%b", i, got, exp);
      end
    end
  endtask

  task automatic test_short();
    logic [4:0] got, exp;
    for (int i = 0; i < 11; i++) begin
      btn_level = (i < 3);
      @(posedge clk); #1;
      exp = '0;
      if (i == 7) exp[4] = 1'b1;
      got = outs();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL short_press edge=%0d got=%b exp=%b", i, got, exp);
      end
    end
  endtask

  task automatic test_double();
    logic [4:0] got, exp;
    for (int i = 0; i < 13; i++) begin
      btn_level = (i < 3) || (i == 5) || (i == 6);
      @(posedge clk); #1;
      exp = '0;
      if (i == 7) exp[3] = 1'b1;
      got = outs();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL double_click edge=%0d got=%b exp=%b", i, got, exp);
      end
    end
  endtask

  task automatic test_long_repeat();
    logic [4:0] got, exp;
    for (int i = 0; i < 21; i++) begin
      btn_level = (i < 15);
      @(posedge clk); #1;
      exp = '0;
      if (i == 8) exp[2] = 1'b1;
      if (i == 11 || i == 14) exp[1] = 1'b1;
      if (i >= 8 && i <= 14) exp[0] = 1'b1;
      got = outs();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL long_repeat edge=%0d got=%b exp=%b", i, got, exp);
      end
    end
  endtask

  task automatic test_second_press_boundary();
    logic [4:0] got, exp;
    // second press lands on the edge where the wait counter hits its terminal value
    for (int i = 0; i < 14; i++) begin
      btn_level = (i < 3) || (i == 7) || (i == 8);
      @(posedge clk); #1;
      exp = '0;
      if (i == 9) exp[3] = 1'b1;
      got = outs();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL second_press_boundary edge=%0d got=%b exp=%b", i, got, exp);
      end
    end
  endtask

  task automatic test_release_at_long_boundary();
    logic [4:0] got, exp;
    for (int i = 0; i < 16; i++) begin
      btn_level = (i < 8);
      @(posedge clk); #1;
      exp = '0;
      if (i == 12) exp[4] = 1'b1;
      got = outs();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL release_long_boundary edge=%0d got=%b exp=%b", i, got, exp);
      end
    end
  endtask

  task automatic test_second_press_long();
    logic [4:0] got, exp;
    for (int i = 0; i < 18; i++) begin
      btn_level = (i < 3) || (i >= 4 && i <= 12);
      @(posedge clk); #1;
      exp = '0;
      if (i == 12) exp[2] = 1'b1;
      if (i == 12) exp[0] = 1'b1;
      got = outs();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL second_press_long edge=%0d got=%b exp=%b", i, got, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] got, exp;
    // double click followed immediately by a short press once IDLE is reached
    for (int i = 0; i < 14; i++) begin
      btn_level = (i == 0) || (i == 2) || (i == 4);
      @(posedge clk); #1;
      exp = '0;
      if (i == 3) exp[3] = 1'b1;
      if (i == 9) exp[4] = 1'b1;
      got = outs();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL back_to_back edge=%0d got=%b exp=%b", i, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid_gesture();
    logic [4:0] got, exp;
    for (int i = 0; i < 11; i++) begin
      btn_level = 1'b1;
      @(posedge clk); #1;
      exp = '0;
      if (i == 8) exp[2] = 1'b1;
      if (i >= 8) exp[0] = 1'b1;
      got = outs();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL reset_mid_setup edge=%0d got=%b exp=%b", i, got, exp);
      end
    end
    reset = 1'b1;
    #1;
    got = outs();
    total++;
    if (got !== 5'b0) begin
      bad++;
      $display("FAIL reset_mid_async got=%b exp=%b", got, 5'b0);
    end
    btn_level = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      got = outs();
      total++;
      if (got !== 5'b0) begin
        bad++;
        $display("FAIL reset_mid_hold edge=%0d got=%b exp=%b", i, got, 5'b0);
      end
    end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      got = outs();
      total++;
      if (got !== 5'b0) begin
        bad++;
        $display("FAIL reset_mid_after edge=%0d got=%b exp=%b", i, got, 5'b0);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    btn_level = 1'b0;
    test_reset();
    test_short();
    test_double();
    test_long_repeat();
    test_second_press_boundary();
    test_release_at_long_boundary();
    test_second_press_long();
    test_back_to_back();
    test_reset_mid_gesture();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
